hc595_chain_receiver: RTL

- Receiving end of the LED-matrix 74HC595 serial link (SH_CP, ST_CP, DS, OE, active-low master reset).
- Oversamples the link in the system clock domain and rebuilds the shift-chain contents. Exposes the latched 595 parallel outputs, the completed 24-bit RGB word, and the row/frame position implied by OE display windows.
- Serves as an in-FPGA display-chain model and as a checker for the matrix driver.

---
 rtl/hc595_chain_receiver.sv | 108 ++++++++++
 1 files changed

// File: rtl/hc595_chain_receiver.sv
// hc595_chain_receiver: oversampling receiver that rebuilds a 74HC595 chain and tracks rows/frames
module hc595_chain_receiver #(
  parameter int WORD_BITS   = 24,
  parameter int SYNC_STAGES = 2,
  parameter int ROWS        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SH_CP,
  input  logic                 ST_CP,
  input  logic                 DS,
  input  logic                 OE,
  input  logic                 MR_n,
  output logic [WORD_BITS-1:0] q_par,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  output logic                 display_on,
  output logic [2:0]           row_num,
  output logic [6:0]           frame_num,
  output logic                 overflow_err,
  output logic                 short_err
);
  localparam int CW = $clog2(WORD_BITS + 2);
  typedef enum logic [1:0] {CLEAR, COLLECT, FULL, OVER} state_t;
  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0]           link_s;
  logic [2:0]           prev_q, prev_d;
  logic [WORD_BITS-1:0] sr_q, sr_d, q_par_q, q_par_d, word_out_q, word_out_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic                 word_valid_q, word_valid_d, display_on_q, display_on_d;
  logic [2:0]           row_q, row_d;
  logic [6:0]           frame_q, frame_d;
  logic                 overflow_q, overflow_d, short_q, short_d;
  logic                 ds_s, mr_ok, sh_rise, st_rise, oe_rise, oe_fall, fill, win_close;
  // link bit order through the synchronizer: {MR_n, OE, ST_CP, SH_CP, DS}
  assign link_s  = sync_q[SYNC_STAGES-1];
  assign ds_s    = link_s[0];
  assign mr_ok   = link_s[4];
  assign sh_rise = link_s[1] & ~prev_q[0];
  assign st_rise = link_s[2] & ~prev_q[1];
  assign oe_rise = link_s[3] & ~prev_q[2];
  assign oe_fall = ~link_s[3] & prev_q[2];
  // the word completes on the shift that takes the count from WORD_BITS-1 to WORD_BITS
  assign fill      = mr_ok & sh_rise & (cnt_q == CW'(WORD_BITS - 1));
  // a close only counts when a window was actually seen opening (ignores OE settling after reset)
  assign win_close = oe_rise & display_on_q;
  assign q_par        = q_par_q;
  assign word_out     = word_out_q;
  assign word_valid   = word_valid_q;
  assign display_on   = display_on_q;
  assign row_num      = row_q;
  assign frame_num    = frame_q;
  assign overflow_err = overflow_q;
  assign short_err    = short_q;
  // next-state logic for synchronizers, shift chain, FSM and display tracking
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], {MR_n, OE, ST_CP, SH_CP, DS}};
    prev_d       = link_s[3:1];
    sr_d         = !mr_ok ? '0 : sh_rise ? {ds_s, sr_q[WORD_BITS-1:1]} : sr_q;
    cnt_d        = !mr_ok ? '0 : (sh_rise && cnt_q != CW'(WORD_BITS + 1)) ? cnt_q + 1'b1 : cnt_q;
    q_par_d      = st_rise ? sr_d : q_par_q;
    state_d      = !mr_ok ? CLEAR :
                   !sh_rise ? state_q :
                   fill ? FULL :
                   (state_q == CLEAR) ? COLLECT :
                   (state_q == FULL) ? OVER : state_q;
    word_out_d   = fill ? sr_d : word_out_q;
    word_valid_d = fill;
    overflow_d   = overflow_q | (mr_ok & sh_rise & (state_q == FULL || state_q == OVER));
    short_d      = short_q | (oe_fall & (state_q != FULL));
    display_on_d = oe_fall ? 1'b1 : oe_rise ? 1'b0 : display_on_q;
    row_d        = win_close ? ((row_q == 3'(ROWS - 1)) ? 3'd0 : row_q + 3'd1) : row_q;
    frame_d      = (win_close && row_q == 3'(ROWS - 1)) ? frame_q + 7'd1 : frame_q;
  end
  // state registers, all cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      prev_q       <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      q_par_q      <= '0;
      state_q      <= CLEAR;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_q      <= 1'b0;
      display_on_q <= 1'b0;
      row_q        <= '0;
      frame_q      <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      q_par_q      <= q_par_d;
      state_q      <= state_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
      short_q      <= short_d;
      display_on_q <= display_on_d;
      row_q        <= row_d;
      frame_q      <= frame_d;
    end
  end
endmodule
